// File: rtl/window_stream_gen_if.sv
// Pixel ingress and window egress handshake bundle for window_stream_gen.
// The slave side is the window generator; the master side is its environment.
interface window_stream_gen_if #(
    parameter int PIX_W = 8,
    parameter int KSIZE = 3
);
    logic [PIX_W-1:0]             i_pixel_data;
    logic                         i_data_valid;
    logic                         o_data_ready;
    logic [KSIZE*KSIZE*PIX_W-1:0] o_pixel_data;
    logic                         o_pixel_data_valid;
    logic                         i_out_ready;
    logic                         o_intr;

    modport slave (
        input  i_pixel_data,
        input  i_data_valid,
        input  i_out_ready,
        output o_data_ready,
        output o_pixel_data,
        output o_pixel_data_valid,
        output o_intr
    );

    modport master (
        output i_pixel_data,
        output i_data_valid,
        output i_out_ready,
        input  o_data_ready,
        input  o_pixel_data,
        input  o_pixel_data_valid,
        input  o_intr
    );
endinterface

// File: rtl/window_stream_gen.sv
// KSIZE x KSIZE sliding-window generator over a ring of KSIZE+1 line buffers.
// Define WINGEN_REPLICATE_EDGE_EN to replicate the last column into padding.
module window_stream_gen #(
    parameter int IMG_WIDTH = 512,
    parameter int PIX_W     = 8,
    parameter int KSIZE     = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    window_stream_gen_if.slave   io_bus
);
    localparam int NBUF = KSIZE + 1;
    localparam int CW   = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int IW   = $clog2(NBUF);
    localparam int SW   = $clog2(NBUF * IMG_WIDTH + 1);
    localparam int WW   = KSIZE * KSIZE * PIX_W;

    localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
    localparam logic [CW:0]   WIDTH_X  = (CW+1)'(IMG_WIDTH);
    localparam logic [IW-1:0] LAST_BUF = IW'(NBUF - 1);
    localparam logic [IW:0]   NBUF_X   = (IW+1)'(NBUF);
    localparam logic [SW-1:0] CAP      = SW'(NBUF * IMG_WIDTH);
    localparam logic [SW-1:0] THRESH   = SW'(KSIZE * IMG_WIDTH);
    localparam logic [SW-1:0] LINE     = SW'(IMG_WIDTH);

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_RD_LINE = 1'b1;

    logic [PIX_W-1:0] r_line [NBUF][IMG_WIDTH];

    logic [CW-1:0] r_wcol;
    logic [IW-1:0] r_wr_idx;
    logic [IW-1:0] r_rd_idx;
    logic [SW-1:0] r_stored;
    logic [CW-1:0] r_rc;
    logic [0:0]    r_state;
    logic [WW-1:0] r_win;
    logic          r_valid;
    logic          r_intr;

    logic w_ready;
    logic w_wr;
    logic w_issue;
    logic w_line_done;
    wire  [WW-1:0] w_win;

    assign w_ready     = (r_stored < CAP);
    assign w_wr        = io_bus.i_data_valid & w_ready;
    assign w_issue     = (r_state == S_RD_LINE) &
                         (~r_valid | io_bus.i_out_ready);
    assign w_line_done = w_issue & (r_rc == LAST_COL);

    // Line storage carries no reset; stale contents are never read
    // because the read side is gated by the stored-pixel count.
    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_line[r_wr_idx][r_wcol] <= io_bus.i_pixel_data;
        end
    end

    for (genvar gr = 0; gr < KSIZE; gr++) begin : g_row
        logic [IW:0]   w_bsum;
        logic [IW-1:0] w_bidx;

        assign w_bsum = {1'b0, r_rd_idx} + (IW+1)'(gr);
        assign w_bidx = (w_bsum >= NBUF_X) ?
                        IW'(w_bsum - NBUF_X) : w_bsum[IW-1:0];

        for (genvar gc = 0; gc < KSIZE; gc++) begin : g_col
            logic [CW:0]      w_col;
            logic [PIX_W-1:0] w_pix;
            logic [PIX_W-1:0] w_pad;

            assign w_col = {1'b0, r_rc} + (CW+1)'(gc);
`ifdef WINGEN_REPLICATE_EDGE_EN
            assign w_pad = r_line[w_bidx][LAST_COL];
`else
            assign w_pad = '0;
`endif
            assign w_pix = (w_col < WIDTH_X) ?
                           r_line[w_bidx][w_col[CW-1:0]] : w_pad;
            assign w_win[(gr*KSIZE+gc)*PIX_W +: PIX_W] = w_pix;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wcol   <= '0;
            r_wr_idx <= '0;
            r_rd_idx <= '0;
            r_stored <= '0;
            r_rc     <= '0;
            r_state  <= S_IDLE;
            r_win    <= '0;
            r_valid  <= 1'b0;
            r_intr   <= 1'b0;
        end else begin
            if (w_wr) begin
                if (r_wcol == LAST_COL) begin
                    r_wcol   <= '0;
                    r_wr_idx <= (r_wr_idx == LAST_BUF) ?
                                '0 : r_wr_idx + IW'(1);
                end else begin
                    r_wcol <= r_wcol + CW'(1);
                end
            end

            // A completing line frees one buffer's worth of pixels.
            case ({w_wr, w_line_done})
                2'b10:   r_stored <= r_stored + SW'(1);
                2'b01:   r_stored <= r_stored - LINE;
                2'b11:   r_stored <= r_stored + SW'(1) - LINE;
                default: r_stored <= r_stored;
            endcase

            case (r_state)
                S_IDLE: begin
                    if (r_stored >= THRESH) begin
                        r_state <= S_RD_LINE;
                    end
                end
                S_RD_LINE: begin
                    if (w_line_done) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_issue) begin
                r_rc <= w_line_done ? '0 : r_rc + CW'(1);
            end

            if (w_line_done) begin
                r_rd_idx <= (r_rd_idx == LAST_BUF) ?
                            '0 : r_rd_idx + IW'(1);
            end

            if (w_issue) begin
                r_win   <= w_win;
                r_valid <= 1'b1;
            end else if (io_bus.i_out_ready) begin
                r_valid <= 1'b0;
            end

            r_intr <= w_line_done;
        end
    end

    assign io_bus.o_data_ready       = w_ready;
    assign io_bus.o_pixel_data       = r_win;
    assign io_bus.o_pixel_data_valid = r_valid;
    assign io_bus.o_intr             = r_intr;
endmodule

// File: tb/tb_window_stream_gen.sv
// Directed bench for window_stream_gen at IMG_WIDTH=8, KSIZE=3, PIX_W=8.
// Pixel (row,col) carries row*16+col.
module tb_window_stream_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    window_stream_gen_if #(.PIX_W(8), .KSIZE(3)) bus ();

    window_stream_gen #(
        .IMG_WIDTH(8),
        .PIX_W(8),
        .KSIZE(3)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .io_bus(bus)
    );

`ifdef WINGEN_REPLICATE_EDGE_EN
    localparam logic [71:0] W6_L0 = 72'h272726171716070706;
`else
    localparam logic [71:0] W6_L0 = 72'h002726001716000706;
`endif
    localparam logic [71:0] W0_L0 = 72'h222120121110020100;
    localparam logic [71:0] W0_L2 = 72'h424140323130222120;
    localparam logic [71:0] W0_L3 = 72'h525150424140323130;

    function automatic logic [7:0] pix(input int r, input int c);
        return 8'(r * 16 + c);
    endfunction

    function automatic logic [71:0] exp_win(input int line, input int col);
        logic [71:0] w;
        int cc;
        w = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                cc = col + c;
                if (cc < 8) begin
                    w[(r*3+c)*8 +: 8] = pix(line + r, cc);
                end else begin
`ifdef WINGEN_REPLICATE_EDGE_EN
                    w[(r*3+c)*8 +: 8] = pix(line + r, 7);
`endif
                end
            end
        end
        return w;
    endfunction

    task automatic chk(input string tag, input logic [71:0] obs,
                       input logic [71:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int pi, input int npix);
        if (pi < npix) begin
            bus.i_data_valid = 1'b1;
            bus.i_pixel_data = pix(pi / 8, pi % 8);
        end else begin
            bus.i_data_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.i_data_valid = 1'b0;
        bus.i_pixel_data = '0;
        bus.i_out_ready  = 1'b1;
        repeat (4) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic run_stream(input int start_pi, input int npix,
                              input int nwin, input int stop_at,
                              input int cap_idx, output int got_x,
                              output int got_intr,
                              output logic [71:0] cap,
                              output logic rdy_at_intr);
        int pi;
        int xf;
        int ni;
        logic acc;
        logic seen;
        pi = start_pi;
        xf = 0;
        ni = 0;
        seen = 1'b0;
        cap = '0;
        rdy_at_intr = 1'b0;
        drive(pi, npix);
        for (int cyc = 0; cyc < 600 && xf < nwin && xf != stop_at; cyc++) begin
            if (bus.o_intr) begin
                ni++;
                if (!seen) begin
                    seen = 1'b1;
                    rdy_at_intr = bus.o_data_ready;
                end
            end
            acc = bus.i_data_valid & bus.o_data_ready;
            if (bus.o_pixel_data_valid && bus.i_out_ready) begin
                if (xf == cap_idx) cap = bus.o_pixel_data;
                chk($sformatf("win_l%0d_c%0d", xf / 8, xf % 8),
                    bus.o_pixel_data, exp_win(xf / 8, xf % 8));
                xf++;
            end
            tick();
            if (acc) begin
                pi++;
                drive(pi, npix);
            end
        end
        got_x = xf;
        got_intr = ni;
    endtask

    task automatic scen2(input string pfx);
        bus.i_out_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            drive(i, 24);
            tick();
        end
        bus.i_data_valid = 1'b0;
        chk({pfx, "_valid_e0"}, 72'(bus.o_pixel_data_valid), 72'd0);
        tick();
        chk({pfx, "_valid_e1"}, 72'(bus.o_pixel_data_valid), 72'd0);
        tick();
        chk({pfx, "_valid_e2"}, 72'(bus.o_pixel_data_valid), 72'd1);
        chk({pfx, "_win0"}, bus.o_pixel_data, W0_L0);
        for (int k = 1; k < 8; k++) begin
            tick();
            chk($sformatf("%s_valid_w%0d", pfx, k),
                72'(bus.o_pixel_data_valid), 72'd1);
            chk($sformatf("%s_win%0d", pfx, k),
                bus.o_pixel_data, exp_win(0, k));
            if (k == 6) begin
                chk({pfx, "_pad_w6"}, bus.o_pixel_data, W6_L0);
                chk({pfx, "_intr_w6"}, 72'(bus.o_intr), 72'd0);
            end
            if (k == 7) chk({pfx, "_intr_w7"}, 72'(bus.o_intr), 72'd1);
        end
        tick();
        chk({pfx, "_intr_after"}, 72'(bus.o_intr), 72'd0);
        chk({pfx, "_valid_after"}, 72'(bus.o_pixel_data_valid), 72'd0);
    endtask

    initial begin
        int gx;
        int gi;
        logic [71:0] cw;
        logic ri;

        bus.i_data_valid = 1'b0;
        bus.i_pixel_data = '0;
        bus.i_out_ready  = 1'b1;

        // Reset values
        do_reset();
        chk("rst_valid", 72'(bus.o_pixel_data_valid), 72'd0);
        chk("rst_intr", 72'(bus.o_intr), 72'd0);
        chk("rst_data", bus.o_pixel_data, 72'd0);
        chk("rst_ready", 72'(bus.o_data_ready), 72'd1);

        // Basic three-row stream
        scen2("s2");

        // Backpressure at window 3
        do_reset();
        for (int i = 0; i < 24; i++) begin
            drive(i, 24);
            tick();
        end
        bus.i_data_valid = 1'b0;
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("bp_win%0d", k), bus.o_pixel_data, exp_win(0, k));
            tick();
        end
        bus.i_out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
            chk($sformatf("bp_hold%0d", s), bus.o_pixel_data, exp_win(0, 3));
            chk($sformatf("bp_hold_v%0d", s),
                72'(bus.o_pixel_data_valid), 72'd1);
            tick();
        end
        bus.i_out_ready = 1'b1;
        for (int k = 3; k < 8; k++) begin
            chk($sformatf("bp_win%0d", k), bus.o_pixel_data, exp_win(0, k));
            tick();
        end
        chk("bp_no_extra", 72'(bus.o_pixel_data_valid), 72'd0);

        // Full buffers with the output stalled
        do_reset();
        bus.i_out_ready = 1'b0;
        for (int i = 0; i < 32; i++) begin
            drive(i, 40);
            if (i == 31) chk("full_ready_p32", 72'(bus.o_data_ready), 72'd1);
            tick();
        end
        drive(32, 40);
        chk("full_ready_low", 72'(bus.o_data_ready), 72'd0);
        for (int s = 0; s < 3; s++) begin
            tick();
            chk($sformatf("full_ready_low%0d", s),
                72'(bus.o_data_ready), 72'd0);
        end
        chk("full_hold_w0", bus.o_pixel_data, W0_L0);
        bus.i_out_ready = 1'b1;
        run_stream(32, 40, 24, -1, 16, gx, gi, cw, ri);
        chk("full_ready_at_intr", 72'(ri), 72'd1);
        chk("full_xfers", 72'(gx), 72'd24);
        chk("full_intrs", 72'(gi), 72'd3);
        chk("full_l2_w0", cw, W0_L2);

        // Six rows through the ring
        do_reset();
        run_stream(0, 48, 32, -1, 24, gx, gi, cw, ri);
        chk("wrap_xfers", 72'(gx), 72'd32);
        chk("wrap_intrs", 72'(gi), 72'd4);
        chk("wrap_l3_w0", cw, W0_L3);
        chk("wrap_idle", 72'(bus.o_pixel_data_valid), 72'd0);

        // Reset in the middle of line 2
        do_reset();
        run_stream(0, 48, 32, 19, -1, gx, gi, cw, ri);
        chk("mid_reached", 72'(gx), 72'd19);
        rst = 1'b1;
        bus.i_data_valid = 1'b0;
        tick();
        chk("mid_rst_valid", 72'(bus.o_pixel_data_valid), 72'd0);
        chk("mid_rst_intr", 72'(bus.o_intr), 72'd0);
        chk("mid_rst_data", bus.o_pixel_data, 72'd0);
        chk("mid_rst_ready", 72'(bus.o_data_ready), 72'd1);
        rst = 1'b0;
        tick();
        scen2("s6");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end
endmodule
